// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one combinational ALU shared round-robin among NREQ
// requesters. Each accepted op is computed in its accept cycle and returned
// one cycle later through a single registered response channel tagged with
// the requester index.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester valid/ready (ready is one-hot or zero)
//   req_op/req_a/req_b  per-requester op code (4b) and operands, slice i
//   rsp_valid/rsp_ready registered response handshake
//   rsp_id/rsp_result   requester index and ALU result
//   stall_cnt           (only with ALU_ARB_STATS_EN) saturating count of
//                       cycles where some request was pending but none accepted
//
// Optional feature macro: ALU_ARB_STATS_EN
//
// Op codes: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 SLT, 5 SLTU, 6 SLL, 7 SRL, 8 SRA,
// 9 ADD, 10..15 return 0.

module alu_share_arbiter #(
   parameter int NBIT = 32,
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*4-1:0]    req_op,
   input  logic [NREQ*NBIT-1:0] req_a,
   input  logic [NREQ*NBIT-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [NBIT-1:0]      rsp_result
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [31:0]          stall_cnt
`endif
);

   localparam int SHW = $clog2(NBIT);

   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  gnt_id;
   logic            gnt_found;
   logic            can_accept;
   logic            hs;
   int              scan_idx;
   logic [3:0]      op_sel;
   logic [NBIT-1:0] a_sel;
   logic [NBIT-1:0] b_sel;
   logic [SHW-1:0]  shamt;
   logic [NBIT-1:0] alu_res;

   // Round-robin search starting at rr_ptr, wrapping modulo NREQ (NREQ need
   // not be a power of two, so the wrap is done in integer arithmetic).
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      scan_idx  = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = (int'(rr_ptr) + k) % NREQ;
         if (!gnt_found && req_valid[scan_idx]) begin
            gnt_found = 1'b1;
            gnt_id    = IDW'(scan_idx);
         end
      end
   end

   // can_accept only looks at registered rsp_valid, so rsp_ready reaches
   // req_ready combinationally but never rsp_valid.
   assign can_accept = !rsp_valid || rsp_ready;
   assign req_ready  = (rst_n && gnt_found && can_accept) ? (NREQ'(1) << gnt_id) : '0;
   assign hs         = |(req_valid & req_ready);

   assign op_sel = req_op[int'(gnt_id)*4 +: 4];
   assign a_sel  = req_a[int'(gnt_id)*NBIT +: NBIT];
   assign b_sel  = req_b[int'(gnt_id)*NBIT +: NBIT];
   assign shamt  = b_sel[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (op_sel)
         4'd1:    alu_res = a_sel & b_sel;
         4'd2:    alu_res = a_sel | b_sel;
         4'd3:    alu_res = a_sel ^ b_sel;
         4'd4:    alu_res = {{(NBIT-1){1'b0}}, ($signed(a_sel) < $signed(b_sel))};
         4'd5:    alu_res = {{(NBIT-1){1'b0}}, (a_sel < b_sel)};
         4'd6:    alu_res = a_sel << shamt;
         4'd7:    alu_res = a_sel >> shamt;
         4'd8:    alu_res = $unsigned($signed(a_sel) >>> shamt);
         4'd9:    alu_res = a_sel + b_sel;
         default: alu_res = '0;
      endcase
   end

   // Response register: reload on handshake (covers the no-bubble case where
   // the consumer drains in the same cycle), clear on drain, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rr_ptr     <= '0;
      end else if (hs) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= gnt_id;
         rsp_result <= alu_res;
         rr_ptr     <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (|req_valid && !hs && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (default build, NBIT=32, NREQ=4).
// Expected responses are queued when a grant is observed and popped when the
// response is due one cycle later.

module tb_alu_share_arbiter;

   localparam int NBIT = 32;
   localparam int NREQ = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [3:0]    req_ready;
   logic [15:0]   req_op = '0;
   logic [127:0]  req_a = '0;
   logic [127:0]  req_b = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [1:0]    rsp_id;
   logic [31:0]   rsp_result;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] res;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   exp_ptr = 0;

   alu_share_arbiter #(.NBIT(NBIT), .NREQ(NREQ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result)
   );

   always #5 clk = ~clk;

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[4*i +: 4]  = op;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   // Reference round-robin pick: first valid at or after p, modulo 4.
   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      q.delete();
      exp_ptr = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) set_req(i, 4'd9, 32'd1, 32'd1);
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold ready=%b valid=%b want 0000/0", req_ready, rsp_valid);
      end
      @(posedge clk); #1;
      req_valid = '0;
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_result !== 32'h0 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d valid=%b ready=%b id=%0d result=%h want 0/0000/0/0",
                     c, rsp_valid, req_ready, rsp_id, rsp_result);
         end
      end
      exp_ptr = 0;
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      set_req(1, 4'd9, 32'h0000_0005, 32'hFFFF_FFFF);
      req_valid = 4'b0010;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL single_ready got=%b want=0010", req_ready);
      end
      e.id = 2'd1; e.res = 32'h4; q.push_back(e);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res || req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL single_rsp valid=%b id=%0d result=%h ready=%b want 1/%0d/%h/0000",
                  rsp_valid, rsp_id, rsp_result, req_ready, e.id, e.res);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_drain valid=%b want 0", rsp_valid);
      end
      exp_ptr = 2;
   endtask

   task automatic test_round_robin();
      logic [3:0] pats [0:9];
      logic [3:0] want;
      int g;
      pats = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1001, 4'b1001, 4'b0110, 4'b0110, 4'hF};
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 4'd5, i, 32'd2);
      for (int c = 0; c < 11; c++) begin
         @(posedge clk); #1;
         req_valid = (c < 10) ? pats[c] : 4'b0000;
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res) begin
               bad++;
               $display("FAIL rr_rsp cyc=%0d valid=%b id=%0d result=%h want 1/%0d/%h",
                        c, rsp_valid, rsp_id, rsp_result, e.id, e.res);
            end
         end
         if (c < 10) begin
            g = pick(req_valid, exp_ptr);
            want = 4'b0001 << g;
            total++;
            if (req_ready !== want) begin
               bad++;
               $display("FAIL rr_grant cyc=%0d ready=%b want=%b", c, req_ready, want);
            end
            e.id = 2'(g);
            e.res = (g < 2) ? 32'd1 : 32'd0;
            q.push_back(e);
            exp_ptr = (g + 1) % 4;
         end
      end
   endtask

   task automatic test_backpressure();
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_req(0, 4'd3, 32'hF0F0_F0F0, 32'hFFFF_0000);
      req_valid = 4'b0001;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL bp_first_ready got=%b want=0001", req_ready);
      end
      e.id = 2'd0; e.res = 32'h0F0F_F0F0; q.push_back(e);
      @(posedge clk); #1;
      set_req(2, 4'd9, 32'd7, 32'd8);
      req_valid = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b1 || rsp_id !== q[0].id || rsp_result !== q[0].res || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d valid=%b id=%0d result=%h ready=%b want 1/%0d/%h/0000",
                     c, rsp_valid, rsp_id, rsp_result, req_ready, q[0].id, q[0].res);
         end
         @(posedge clk); #1;
         if (c == 2) rsp_ready = 1'b1;
      end
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (req_ready !== 4'b0100 || rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res) begin
         bad++;
         $display("FAIL bp_release ready=%b valid=%b id=%0d result=%h want 0100/1/%0d/%h",
                  req_ready, rsp_valid, rsp_id, rsp_result, e.id, e.res);
      end
      e.id = 2'd2; e.res = 32'd15; q.push_back(e);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res) begin
         bad++;
         $display("FAIL bp_second valid=%b id=%0d result=%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_result, e.id, e.res);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_drain valid=%b want 0", rsp_valid);
      end
      exp_ptr = 3;
   endtask

   // Single requester held valid: granted every cycle, full throughput.
   task automatic test_back_to_back_ops();
      logic [3:0]  ops [0:12];
      logic [31:0] as  [0:12];
      logic [31:0] bs  [0:12];
      logic [31:0] rs  [0:12];
      ops = '{4'd6, 4'd8, 4'd7, 4'd8, 4'd4, 4'd5, 4'd1, 4'd2, 4'd9, 4'd0, 4'd12, 4'd3, 4'd8};
      as  = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h5, 32'h5, 32'h5, 32'h4000_0000};
      bs  = '{32'h21, 32'h4, 32'h24, 32'h3F, 32'h1, 32'h1,
              32'hFF00_FF00, 32'h0F00_0000, 32'h2, 32'h6, 32'h6, 32'h6, 32'h21};
      rs  = '{32'h2, 32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFF, 32'h1, 32'h0,
              32'hF000_F000, 32'hFFF0_F0F0, 32'h1, 32'h0, 32'h0, 32'h3, 32'h2000_0000};
      rsp_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         if (c < 13) begin
            set_req(3, ops[c], as[c], bs[c]);
            req_valid = 4'b1000;
         end else begin
            req_valid = 4'b0000;
         end
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res) begin
               bad++;
               $display("FAIL ops_rsp cyc=%0d valid=%b id=%0d result=%h want 1/%0d/%h",
                        c, rsp_valid, rsp_id, rsp_result, e.id, e.res);
            end
         end
         if (c < 13) begin
            total++;
            if (req_ready !== 4'b1000) begin
               bad++;
               $display("FAIL ops_ready cyc=%0d ready=%b want=1000", c, req_ready);
            end
            e.id = 2'd3; e.res = rs[c]; q.push_back(e);
         end
      end
      exp_ptr = 0;
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_req(1, 4'd9, 32'd1, 32'd1);
      req_valid = 4'b0010;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL rmid_ready got=%b want=0010", req_ready);
      end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'd2) begin
         bad++;
         $display("FAIL rmid_pending valid=%b id=%0d result=%h want 1/1/2", rsp_valid, rsp_id, rsp_result);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL rmid_async valid=%b id=%0d result=%h ready=%b want 0/0/0/0000",
                  rsp_valid, rsp_id, rsp_result, req_ready);
      end
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      set_req(0, 4'd9, 32'd10, 32'd20);
      req_valid = 4'hF;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL rmid_regrant ready=%b want=0001", req_ready);
      end
      e.id = 2'd0; e.res = 32'd30; q.push_back(e);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res) begin
         bad++;
         $display("FAIL rmid_rsp valid=%b id=%0d result=%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_result, e.id, e.res);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_back_to_back_ops();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
